// File: rtl/uart_rx_os_if.sv
// rtl/uart_rx_os_if.sv - received-word handshake bundle for uart_rx_os
//
// Signals:
//   data        received word, LSB first on the line
//   valid       data and error flags are held and valid
//   ready       consumer accepts the word when valid && ready
//   parity_err  parity mismatch for the held word
//   frame_err   a stop bit was sampled low for the held word
//   overrun     sticky, a completed frame was dropped while a word was held
// Modports:
//   master      receiver side (drives word and flags, samples ready)
//   slave       consumer side (samples word and flags, drives ready)
interface uart_rx_os_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output data, valid, parity_err, frame_err, overrun,
    input  ready
  );

  modport slave (
    input  data, valid, parity_err, frame_err, overrun,
    output ready
  );
endinterface

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling UART receiver with held-word handshake
//
// Ports:
//   clk     single clock
//   rst     synchronous active-high reset
//   rxd     asynchronous serial line, idle high
//   enable  permits detection of new start bits (never aborts a frame)
//   busy    high whenever the receiver is not idle
//   rx      word/flag handshake (uart_rx_os_if.master)
module uart_rx_os #(
  parameter int CLOCK_FREQ = 12000000,
  parameter int BAUD_RATE  = 19200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  input  logic enable,
  output logic busy,
  uart_rx_os_if.master rx
);

  localparam int DIV  = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OSW  = $clog2(OVERSAMPLE);

  localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(DIV - 1);
  localparam logic [OSW-1:0]  OS_HALF   = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0]  OS_LAST   = OSW'(OVERSAMPLE - 1);
  localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);

  generate
    if (DIV < 1) begin : g_bad_div
      $error("uart_rx_os: CLOCK_FREQ too low for BAUD_RATE*OVERSAMPLE");
    end
    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
      $error("uart_rx_os: OVERSAMPLE must be even and >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
      $error("uart_rx_os: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_par
      $error("uart_rx_os: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_rx_os: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  // Line synchronizer; flops reset to the idle level so reset never
  // looks like a start bit.
  logic rxd_s1, rxd_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
    end else begin
      rxd_s1 <= rxd;
      rxd_s2 <= rxd_s1;
    end
  end

  // Free-running oversample tick. With DIV == 1 the counter stays at 0
  // and the tick is asserted every clk.
  logic [DIVW-1:0] div_cnt;
  logic            tick;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Frame state and datapath
  state_t               state, state_n;
  logic [OSW-1:0]       os_cnt, os_n;
  logic [3:0]           bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 perr, perr_n;
  logic                 ferr, ferr_n;
  logic                 done;
  logic                 par_exp;

  // Expected parity bit: even parity makes the total count of ones even,
  // so the bit equals the XOR of the word; odd parity is its inverse.
  assign par_exp = (PARITY == 1) ? ~(^shift) : (^shift);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      os_cnt  <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      state   <= state_n;
      os_cnt  <= os_n;
      bit_cnt <= bit_n;
      shift   <= shift_n;
      perr    <= perr_n;
      ferr    <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    os_n    = os_cnt;
    bit_n   = bit_cnt;
    shift_n = shift;
    perr_n  = perr;
    ferr_n  = ferr;
    done    = 1'b0;

    if (tick) begin
      case (state)
        S_IDLE: begin
          if (enable && !rxd_s2) begin
            state_n = S_START;
            os_n    = '0;
            bit_n   = '0;
            perr_n  = 1'b0;
            ferr_n  = 1'b0;
          end
        end

        // Re-check the line at mid start bit; a high sample was a glitch.
        S_START: begin
          if (os_cnt == OS_HALF) begin
            os_n    = '0;
            state_n = rxd_s2 ? S_IDLE : S_DATA;
          end else begin
            os_n = os_cnt + 1'b1;
          end
        end

        // Shift in from the top so the first bit ends up in bit 0.
        S_DATA: begin
          if (os_cnt == OS_LAST) begin
            os_n    = '0;
            shift_n = {rxd_s2, shift[DATA_BITS-1:1]};
            if (bit_cnt == DATA_LAST) begin
              bit_n   = '0;
              state_n = (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_n = bit_cnt + 1'b1;
            end
          end else begin
            os_n = os_cnt + 1'b1;
          end
        end

        S_PARITY: begin
          if (os_cnt == OS_LAST) begin
            os_n    = '0;
            perr_n  = (rxd_s2 != par_exp);
            state_n = S_STOP;
          end else begin
            os_n = os_cnt + 1'b1;
          end
        end

        // The last stop sample completes the frame; a low stop bit means
        // the line may be in break, so wait for it to go high first.
        S_STOP: begin
          if (os_cnt == OS_LAST) begin
            os_n   = '0;
            ferr_n = ferr | ~rxd_s2;
            if (bit_cnt == STOP_LAST) begin
              bit_n   = '0;
              done    = 1'b1;
              state_n = ferr_n ? S_WAIT_HIGH : S_IDLE;
            end else begin
              bit_n = bit_cnt + 1'b1;
            end
          end else begin
            os_n = os_cnt + 1'b1;
          end
        end

        S_WAIT_HIGH: begin
          if (rxd_s2) begin
            state_n = S_IDLE;
          end
        end

        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != S_IDLE);

  // Held-word output stage
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 perr_q;
  logic                 ferr_q;
  logic                 ovr_q;
  logic                 hs;

  assign hs = valid_q && rx.ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (done && (!valid_q || hs)) begin
        // Slot is free or being emptied this cycle: take the new word.
        data_q  <= shift;
        perr_q  <= perr_n;
        ferr_q  <= ferr_n;
        valid_q <= 1'b1;
      end else if (hs) begin
        valid_q <= 1'b0;
      end

      // A frame completing against an unaccepted word is dropped.
      if (done && valid_q && !hs) begin
        ovr_q <= 1'b1;
      end else if (hs) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign rx.data       = data_q;
  assign rx.valid      = valid_q;
  assign rx.parity_err = perr_q;
  assign rx.frame_err  = ferr_q;
  assign rx.overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - directed self-checking bench for uart_rx_os
//
// Two receivers at 16 clk per bit: dut0 is 8N1, dut1 is 8E1.
module tb_uart_rx_os;

  logic clk;
  logic rst;
  logic rxd0, rxd1;
  logic enable;
  logic busy0, busy1;

  uart_rx_os_if #(.DATA_BITS(8)) rx0 ();
  uart_rx_os_if #(.DATA_BITS(8)) rx1 ();

  uart_rx_os #(
    .CLOCK_FREQ(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) dut0 (
    .clk(clk), .rst(rst), .rxd(rxd0), .enable(enable), .busy(busy0), .rx(rx0)
  );

  uart_rx_os #(
    .CLOCK_FREQ(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
  ) dut1 (
    .clk(clk), .rst(rst), .rxd(rxd1), .enable(enable), .busy(busy1), .rx(rx1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Valid-cycle counters and last captured word, sampled mid-cycle.
  int         vcnt0 = 0;
  int         vcnt1 = 0;
  logic [7:0] cap_data0 = '0, cap_data1 = '0;
  logic       cap_perr0 = 1'b0, cap_perr1 = 1'b0;
  logic       cap_ferr0 = 1'b0, cap_ferr1 = 1'b0;

  always @(negedge clk) begin
    if (rx0.valid === 1'b1) begin
      vcnt0     = vcnt0 + 1;
      cap_data0 = rx0.data;
      cap_perr0 = rx0.parity_err;
      cap_ferr0 = rx0.frame_err;
    end
    if (rx1.valid === 1'b1) begin
      vcnt1     = vcnt1 + 1;
      cap_data1 = rx1.data;
      cap_perr1 = rx1.parity_err;
      cap_ferr1 = rx1.frame_err;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input bit sel, input logic b);
    if (sel) rxd1 = b;
    else     rxd0 = b;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] word,
                            input bit use_par, input logic par_bit);
    set_line(sel, 1'b0);
    tick(16);
    for (int i = 0; i < 8; i++) begin
      set_line(sel, word[i]);
      tick(16);
    end
    if (use_par) begin
      set_line(sel, par_bit);
      tick(16);
    end
    set_line(sel, 1'b1);
    tick(16);
  endtask

  int v0;

  initial begin
    rst    = 1'b1;
    rxd0   = 1'b1;
    rxd1   = 1'b1;
    enable = 1'b1;
    rx0.ready = 1'b1;
    rx1.ready = 1'b1;
    tick(3);

    // Reset state
    check("rst_valid",  rx0.valid, 0);
    check("rst_data",   rx0.data, 0);
    check("rst_busy",   busy0, 0);
    check("rst_overrun", rx0.overrun, 0);
    check("rst_perr",   rx0.parity_err, 0);
    check("rst_ferr",   rx0.frame_err, 0);
    rst = 1'b0;
    tick(5);

    // 8N1 frame 0xA5 with ready high
    v0 = vcnt0;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0);
    tick(10);
    check("a5_valid_cycles", vcnt0 - v0, 1);
    check("a5_data", cap_data0, 8'hA5);
    check("a5_perr", cap_perr0, 0);
    check("a5_ferr", cap_ferr0, 0);
    check("a5_busy_after", busy0, 0);
    check("a5_overrun", rx0.overrun, 0);

    // Even parity, word 0x03 sent with parity bit 1 (expected 0)
    v0 = vcnt1;
    send_frame(1'b1, 8'h03, 1'b1, 1'b1);
    tick(10);
    check("par_valid_cycles", vcnt1 - v0, 1);
    check("par_data", cap_data1, 8'h03);
    check("par_perr", cap_perr1, 1);
    check("par_ferr", cap_ferr1, 0);

    // Break: line low for 20 bit times
    v0 = vcnt0;
    set_line(1'b0, 1'b0);
    tick(320);
    check("brk_valid_cycles", vcnt0 - v0, 1);
    check("brk_data", cap_data0, 8'h00);
    check("brk_ferr", cap_ferr0, 1);
    check("brk_busy_wait_high", busy0, 1);
    set_line(1'b0, 1'b1);
    tick(4);
    check("brk_busy_released", busy0, 0);
    tick(10);
    v0 = vcnt0;
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0);
    tick(10);
    check("post_brk_valid_cycles", vcnt0 - v0, 1);
    check("post_brk_data", cap_data0, 8'h3C);
    check("post_brk_ferr", cap_ferr0, 0);

    // Overrun: ready low, back-to-back 0x11 then 0x22
    rx0.ready = 1'b0;
    send_frame(1'b0, 8'h11, 1'b0, 1'b0);
    send_frame(1'b0, 8'h22, 1'b0, 1'b0);
    tick(10);
    check("ovr_valid_held", rx0.valid, 1);
    check("ovr_data_held", rx0.data, 8'h11);
    check("ovr_flag", rx0.overrun, 1);
    rx0.ready = 1'b1;
    tick(1);
    rx0.ready = 1'b0;
    check("ovr_valid_cleared", rx0.valid, 0);
    check("ovr_flag_cleared", rx0.overrun, 0);
    rx0.ready = 1'b1;
    tick(10);

    // Glitch: 4-clk low pulse
    v0 = vcnt0;
    set_line(1'b0, 1'b0);
    tick(4);
    set_line(1'b0, 1'b1);
    tick(2);
    check("glitch_busy_in_start", busy0, 1);
    tick(14);
    check("glitch_busy_after", busy0, 0);
    check("glitch_no_valid", vcnt0 - v0, 0);
    tick(10);

    // Reset during data bit 3 of 0x5A (bits LSB first: 0,1,0,1,...)
    v0 = vcnt0;
    set_line(1'b0, 1'b0); tick(16);
    set_line(1'b0, 1'b0); tick(16);
    set_line(1'b0, 1'b1); tick(16);
    set_line(1'b0, 1'b0); tick(16);
    set_line(1'b0, 1'b1); tick(8);
    rst = 1'b1;
    tick(1);
    check("rst_mid_busy", busy0, 0);
    check("rst_mid_valid", rx0.valid, 0);
    rst = 1'b0;
    set_line(1'b0, 1'b1);
    tick(40);
    check("rst_mid_no_valid", vcnt0 - v0, 0);
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0);
    tick(10);
    check("post_rst_valid_cycles", vcnt0 - v0, 1);
    check("post_rst_data", cap_data0, 8'h5A);
    check("post_rst_perr", cap_perr0, 0);
    check("post_rst_ferr", cap_ferr0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 12000000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 19200, line bit rate.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit (even, >= 4).
REQ-004 SHALL have parameter DATA_BITS, default 8, data bits per frame (5..9).
REQ-005 SHALL have parameter PARITY, default 0, parity mode (0 none, 1 odd, 2 even).
REQ-006 SHALL have parameter STOP_BITS, default 1, stop bits checked per frame (1 or 2).
REQ-007 SHALL have port clk, input, 1, the single clock.
REQ-008 SHALL have port rst, input, 1, reset (synchronous, active-high).
REQ-009 SHALL have port rxd, input, 1, asynchronous serial line, idle high.
REQ-010 SHALL have port enable, input, 1, permits detection of new start bits.
REQ-011 SHALL have port data, output, DATA_BITS, received word, LSB first on line.
REQ-012 SHALL have port valid, output, 1, data and error flags are held and valid.
REQ-013 SHALL have port ready, input, 1, consumer accepts word when valid && ready.
REQ-014 SHALL have port parity_err, output, 1, parity mismatch for the held word.
REQ-015 SHALL have port frame_err, output, 1, a stop bit was sampled low for the held word.
REQ-016 SHALL have port overrun, output, 1, sticky flag set when a completed frame was dropped.
REQ-017 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-018 SHALL pass rxd through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-019 SHALL generate a one-clk tick every DIV = CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE) clks from a free-running counter; DIV < 1 SHALL be an elaboration error.
REQ-020 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH; all state advances and samples occur only on tick cycles.
REQ-021 IDLE: on a tick with enable=1 and rxd=0 -> START, sub-bit counter os_cnt=0; enable=0 ignores start bits but never aborts a frame in progress.
REQ-022 START: os_cnt increments per tick; at os_cnt == OVERSAMPLE/2-1 sample rxd: 1 -> IDLE (glitch, no output), 0 -> DATA with os_cnt=0.
REQ-023 DATA/PARITY/STOP: sample at os_cnt == OVERSAMPLE-1 (mid-bit), then reset os_cnt to 0.
REQ-024 DATA: shift DATA_BITS samples LSB first; after the last -> PARITY if PARITY != 0, else STOP.
REQ-025 PARITY: compute error as received parity bit != (odd: ~^data, even: ^data) of the word.
REQ-026 STOP: sample STOP_BITS bits; any low sample sets the frame error; after the last sample -> IDLE, or -> WAIT_HIGH if a frame error occurred.
REQ-027 WAIT_HIGH: remain until synchronized rxd == 1 (break condition), then -> IDLE.
REQ-028 On the clk after the final stop-bit sample, data, parity_err and frame_err SHALL load and valid SHALL be 1; frames with errors are still delivered.
REQ-029 valid SHALL hold, with data and flags stable, until a cycle with valid && ready, then clear next clk.
REQ-030 Frame completion while valid=1 and no handshake that cycle: new word discarded, held word unchanged, overrun set.
REQ-031 Frame completion in the same cycle as a handshake: new word loads, valid stays 1, no overrun.
REQ-032 overrun SHALL clear on the next handshake unless a new overrun occurs that same cycle.

Reset
REQ-033 rst=1 at a clk edge SHALL force state IDLE, synchronizer flops 1, all counters 0, data 0, valid/parity_err/frame_err/overrun/busy 0.
REQ-034 Reset mid-frame SHALL abort the frame with no valid pulse; reception restarts from the next start bit after release.

Verification (CLOCK_FREQ=1600000, BAUD_RATE=100000, OVERSAMPLE=16 -> 16 clk per bit)
REQ-035 8N1 frame 0xA5, ready=1 -> valid for exactly 1 clk, data=0xA5, all error flags 0, busy low afterwards.
REQ-036 PARITY=2, frame 0x03 with parity bit 1 -> valid, data=0x03, parity_err=1, frame_err=0.
REQ-037 rxd held low 20 bit times -> one word data=0x00, frame_err=1; busy stays 1 (WAIT_HIGH) until rxd returns high; a following frame 0x3C is received cleanly.
REQ-038 ready=0, back-to-back frames 0x11, 0x22 -> data=0x11, overrun=1; ready=1 one clk -> valid=0, overrun=0 next clk.
REQ-039 rxd low pulse of 4 clks -> busy returns 0 after the START sample, valid never asserts.
REQ-040 rst pulsed during data bit 3 -> next clk busy=0, valid=0; subsequent frame 0x5A -> data=0x5A, no errors.
